cicero_job_scheduler: RTL
=========================

// Module: cicero_job_scheduler
// PURPOSE
//  Sequences the CICERO engine's register interface for batches of match jobs. A job is a (start,end) string-pointer pair.
//  Jobs are queued in a FIFO and run one at a time: program pointers, issue CMD_START, poll status, fetch elapsed cycles.
//  Each job yields one result record. Sits between the host/DMA job source and AXI_top's register ports.
// PARAMETERS
//  JOB_DEPTH      4     job FIFO entries; power of 2, >=2
//  START_WAIT     8     max cycles after CMD_START for status to reach STATUS_RUNNING
//  TIMEOUT_CYCLES 65535 max cycles in RUNNING (watchdog, only with SCHED_TIMEOUT_EN)
// PORTS
//  clk             in  1         clock
//  rst             in  1         synchronous, active-high reset
//  job_valid       in  1         job offered
//  job_ready       out 1         FIFO not full; job accepted when valid&&ready
//  job_start_ptr   in  REG_WIDTH first string byte address
//  job_end_ptr     in  REG_WIDTH last string byte address (inclusive)
//  res_valid       out 1         result record available
//  res_ready       in  1         result consumed when valid&&ready
//  res_accept      out 1         1 = STATUS_ACCEPTED, 0 = otherwise
//  res_error       out 1         start never ran, bad final status, or timeout
//  res_cc          out REG_WIDTH elapsed clock count read back (0 on error)
//  busy            out 1         FSM not in IDLE or FIFO non-empty
//  jobs_done       out 16        completed result count, wraps at 2^16
//  start_cc_pointer_register out REG_WIDTH to AXI_top
//  end_cc_pointer_register   out REG_WIDTH to AXI_top
//  cmd_register    out REG_WIDTH to AXI_top
//  status_register in  REG_WIDTH from AXI_top
//  data_o_register in  REG_WIDTH from AXI_top
// BEHAVIOUR
//  Reset values: cmd_register=CMD_NOP, pointers=0, res_*=0, busy=0, jobs_done=0, FIFO empty, FSM=IDLE.
//  Reset mid-job is abandoned: no result, CMD_NOP on the next edge.
//  FSM states and transitions:
//   IDLE: FIFO non-empty -> pop, latch pointers -> SETUP.
//   SETUP: 1 cycle with pointers stable -> START.
//   START: cmd=CMD_START held until status==STATUS_RUNNING, then -> WAIT.
//          After START_WAIT cycles without RUNNING -> error result.
//   WAIT: cmd=CMD_NOP; stay while status==STATUS_RUNNING.
//          ACCEPTED or REJECTED -> latch res_accept -> READCC.
//          Any other status -> error result.
//   READCC: cmd=CMD_READ_ELAPSED_CLOCK for 1 cycle -> CAPTURE.
//   CAPTURE: res_cc<=data_o_register, cmd=CMD_NOP -> RESULT.
//   RESULT: res_valid=1, fields stable until res_ready; on handshake jobs_done++ -> IDLE.
//  Error result: res_error=1, res_accept=0, res_cc=0 -> RESULT.
//  Pointers hold the last job's values; they change only on the IDLE->SETUP edge.
//  FIFO: push and pop in the same cycle are allowed, including when full (pop frees a slot).
//   job_ready is combinational from FIFO full only. Pointer order is preserved.
//  Min latency, FIFO-empty job to res_valid: 1 (push) + 1 (IDLE pop) + SETUP + START(>=1) + engine time + READCC + CAPTURE.
//  Only one job is outstanding at the engine; at most one result record is held.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined: 32-bit watchdog counts cycles in WAIT.
//   Reaching TIMEOUT_CYCLES -> cmd=CMD_NOP, error result -> RESULT. Counter clears on SETUP.
//  Undefined: no watchdog; WAIT persists until status leaves RUNNING.
// STRUCTURE
//  Shared package (AXI_package): REG_WIDTH, CMD_NOP/CMD_START/CMD_READ_ELAPSED_CLOCK,
//   STATUS_RUNNING/ACCEPTED/REJECTED, and new typedef sched_state_t enum
//   {IDLE,SETUP,START,WAIT,READCC,CAPTURE,RESULT}.
//  Sub-module job_fifo #(WIDTH=2*REG_WIDTH, DEPTH=JOB_DEPTH): sync FIFO, registered outputs, full/empty flags.
// TESTING (stub engine model driving status/data_o)
//  T1 single job (0x40,0x7F); engine RUNNING 20 cycles then ACCEPTED, data_o=23
//     -> pointers 0x40/0x7F, one CMD_START pulse, res accept=1 cc=23 error=0, jobs_done=1.
//  T2 push 5 jobs with JOB_DEPTH=4, engine busy -> job_ready low on 5th until first pop;
//     5 results in push order, alternating REJECTED/ACCEPTED as the stub dictates.
//  T3 res_ready held low 10 cycles -> res_* stable, no new CMD_START, next job starts after handshake.
//  T4 engine never shows RUNNING -> after START_WAIT=8 cycles res_error=1, cc=0, cmd back to CMD_NOP.
//  T5 rst asserted during WAIT with 2 jobs queued -> next cycle cmd=CMD_NOP, job_ready=1, busy=0, no results.
//  T6 SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, engine stuck RUNNING -> error result at cycle 100 of WAIT;
//     without the macro, no result.

Source files
------------

// File: rtl/cicero_job_scheduler_pkg.sv
// Shared definitions for the CICERO job scheduler: register width, engine
// command/status encodings and the scheduler state type.
package cicero_job_scheduler_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        READCC,
        CAPTURE,
        RESULT
    } sched_state_t;

endpackage

// File: rtl/cicero_job_scheduler_job_fifo.sv
// Synchronous job FIFO with registered full/empty flags. Simultaneous push and
// pop are allowed even when full, since the pop frees the slot being written.
module job_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cicero_job_scheduler.sv
// CICERO job scheduler: queues (start,end) pointer jobs and drives the engine
// register interface for each one, producing one result record per job.
// Optional watchdog on the WAIT state is enabled with `define SCHED_TIMEOUT_EN.
//
//  state   | meaning
//  IDLE    | waiting for a queued job; pops it and latches pointers
//  SETUP   | pointers stable for one cycle before the start command
//  START   | CMD_START held until engine reports RUNNING (bounded by START_WAIT)
//  WAIT    | engine running; waits for ACCEPTED/REJECTED
//  READCC  | CMD_READ_ELAPSED_CLOCK issued for one cycle
//  CAPTURE | elapsed cycle count sampled from data_o_register
//  RESULT  | result record presented until res_ready
module cicero_job_scheduler
    import cicero_job_scheduler_pkg::*;
#(
    parameter int JOB_DEPTH  = 4,
    parameter int START_WAIT = 8
`ifdef SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [REG_WIDTH-1:0] job_start_ptr,
    input  logic [REG_WIDTH-1:0] job_end_ptr,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_accept,
    output logic                 res_error,
    output logic [REG_WIDTH-1:0] res_cc,
    output logic                 busy,
    output logic [15:0]          jobs_done,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    output logic [REG_WIDTH-1:0] end_cc_pointer_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    input  logic [REG_WIDTH-1:0] status_register,
    input  logic [REG_WIDTH-1:0] data_o_register
);

    localparam int SW_W = $clog2(START_WAIT + 1);

    sched_state_t           state, state_next;
    logic [REG_WIDTH-1:0]   cmd_next;
    logic [SW_W-1:0]        start_timer;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*REG_WIDTH-1:0] fifo_dout;
    logic                   err_next;
`ifdef SCHED_TIMEOUT_EN
    logic [31:0]            wd_timer;
`endif

    job_fifo #(
        .WIDTH (2*REG_WIDTH),
        .DEPTH (JOB_DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (job_valid && !fifo_full),
        .din   ({job_start_ptr, job_end_ptr}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign job_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign res_valid = (state == RESULT);

    // Next state; the command register follows the state being entered
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = START;
            START: begin
                if (status_register == STATUS_RUNNING) begin
                    state_next = WAIT;
                end else if (start_timer == '0) begin
                    err_next   = 1'b1;
                    state_next = RESULT;
                end
            end
            WAIT: begin
                if (status_register == STATUS_RUNNING) begin
`ifdef SCHED_TIMEOUT_EN
                    if (wd_timer == '0) begin
                        err_next   = 1'b1;
                        state_next = RESULT;
                    end
`endif
                end else if (status_register == STATUS_ACCEPTED ||
                             status_register == STATUS_REJECTED) begin
                    state_next = READCC;
                end else begin
                    err_next   = 1'b1;
                    state_next = RESULT;
                end
            end
            READCC:  state_next = CAPTURE;
            CAPTURE: state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   cmd_next = CMD_START;
            READCC:  cmd_next = CMD_READ_ELAPSED_CLOCK;
            default: cmd_next = CMD_NOP;
        endcase
    end

    // State, engine registers, result record and start timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            cmd_register              <= CMD_NOP;
            start_cc_pointer_register <= '0;
            end_cc_pointer_register   <= '0;
            res_accept                <= 1'b0;
            res_error                 <= 1'b0;
            res_cc                    <= '0;
            jobs_done                 <= '0;
            start_timer               <= '0;
        end else begin
            state        <= state_next;
            cmd_register <= cmd_next;

            if (fifo_pop) begin
                start_cc_pointer_register <= fifo_dout[2*REG_WIDTH-1:REG_WIDTH];
                end_cc_pointer_register   <= fifo_dout[REG_WIDTH-1:0];
                res_accept                <= 1'b0;
                res_error                 <= 1'b0;
                res_cc                    <= '0;
            end

            if (state == SETUP) begin
                start_timer <= SW_W'(START_WAIT - 1);
            end else if (state == START && start_timer != '0) begin
                start_timer <= start_timer - SW_W'(1);
            end

            if (state == WAIT && state_next == READCC) begin
                res_accept <= (status_register == STATUS_ACCEPTED);
            end
            if (state == CAPTURE) begin
                res_cc <= data_o_register;
            end
            if (err_next) begin
                res_error  <= 1'b1;
                res_accept <= 1'b0;
                res_cc     <= '0;
            end

            if (state == RESULT && res_ready) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    // Watchdog down-counter for the WAIT state; error at terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_timer <= '0;
        end else if (state == SETUP) begin
            wd_timer <= 32'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT && wd_timer != '0) begin
            wd_timer <= wd_timer - 32'd1;
        end
    end
`endif

endmodule
